node_stream_loader: RTL

//  wclk-domain sequencer that streams kd-tree internal-node words (11-bit index/median halves) from a
//  1-cycle-latency node memory into the write side of the SyncFIFO feeding the aggregator/internal_node_tree.

---
 rtl/kd_pkg.sv | 7 +
 rtl/node_stream_loader_skid_buf2.sv | 41 ++++
 rtl/node_stream_loader.sv | 98 +++++++++
 3 files changed

// File: rtl/kd_pkg.sv
// Shared kd-tree definitions: default node-word geometry and the loader state encoding.
package kd_pkg;
    localparam int KD_DSIZE      = 11;
    localparam int KD_ADDR_WIDTH = 9;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} ld_state_t;
endpackage

// File: rtl/node_stream_loader_skid_buf2.sv
// Two-entry FIFO that absorbs the node-memory read latency; push and pop may coincide at any
// occupancy, including full, since the head is read combinationally before the edge.
module skid_buf2 #(
    parameter int W = 11
) (
    input  logic         wclk,
    input  logic         wrst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [1:0][W-1:0] mem;
    logic              wr_idx;
    logic              rd_idx;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            mem    <= '0;
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_idx] <= din;
                wr_idx      <= ~wr_idx;
            end
            if (pop)
                rd_idx <= ~rd_idx;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout = mem[rd_idx];
endmodule

// File: rtl/node_stream_loader.sv
// Streams kd-tree node words from a 1-cycle-latency memory into the SyncFIFO write port,
// never issuing a read unless its data is guaranteed a slot in the skid buffer.
module node_stream_loader
    import kd_pkg::*;
#(
    parameter int DSIZE      = KD_DSIZE,
    parameter int ADDR_WIDTH = KD_ADDR_WIDTH
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DSIZE-1:0]      mem_rdata,
    input  logic                  fifo_full_n,
    output logic                  fifo_enq,
    output logic [DSIZE-1:0]      fifo_wdata,
    output logic                  busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   words_sent
);
    localparam int CW = ADDR_WIDTH + 1;

    ld_state_t     state, state_nxt;
    logic [CW-1:0] rd_ptr, num_q, words_q;
    logic          rd_inflight;
    logic [1:0]    buf_cnt;
    logic [1:0]    occ;
    logic          start_ok, last_enq, flush;

    assign start_ok = (state == IDLE) && start && !abort;
    assign occ      = buf_cnt + {1'b0, rd_inflight};
    assign last_enq = fifo_enq && ((words_q + CW'(1)) == num_q);
    assign flush    = (state == FETCH) && abort;

    always_ff @(posedge wclk) begin
        if (!wrst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = (num_words == '0) ? DONE : FETCH;
            FETCH:   if (abort) state_nxt = IDLE;
                     else if (last_enq) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A full buffer may still accept a read when the head leaves this cycle.
    always_comb begin
        fifo_enq  = (state == FETCH) && !abort && (buf_cnt != 2'd0) && fifo_full_n;
        mem_ren   = (state == FETCH) && !abort && (rd_ptr < num_q) &&
                    ((occ < 2'd2) || fifo_enq);
        busy      = (state == FETCH) || (state == DONE);
        load_done = (state == DONE);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            rd_ptr      <= '0;
            num_q       <= '0;
            words_q     <= '0;
            rd_inflight <= 1'b0;
        end else if (start_ok) begin
            rd_ptr      <= '0;
            num_q       <= num_words;
            words_q     <= '0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= mem_ren;
            if (mem_ren)
                rd_ptr <= rd_ptr + CW'(1);
            if (fifo_enq)
                words_q <= words_q + CW'(1);
        end
    end

    skid_buf2 #(.W(DSIZE)) u_skid (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .flush  (flush),
        .push   (rd_inflight),
        .pop    (fifo_enq),
        .din    (mem_rdata),
        .dout   (fifo_wdata),
        .count  (buf_cnt)
    );

    assign mem_addr   = rd_ptr[ADDR_WIDTH-1:0];
    assign words_sent = words_q;
endmodule
